// File: rtl/rv_plic_claim_pkg.sv
// Shared types for the PLIC hardware claim/complete sequencer.
// The claim FSM walks IDLE -> CLAIM -> HOLD -> OFFER once per claimed interrupt.
package rv_plic_claim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAIM = 2'd1,
        HOLD  = 2'd2,
        OFFER = 2'd3
    } claim_state_e;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO holding the in-flight (claimed, not yet completed) interrupt IDs.
// Optional pass-through lets a write bypass storage when the FIFO is empty and read at once.
module prim_fifo_sync #(
    parameter int Width  = 8,
    parameter int Depth  = 4,
    parameter bit Pass   = 1'b0,
    parameter int DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]  mem [Depth];
    logic [PtrW-1:0]   wptr_q;
    logic [PtrW-1:0]   rptr_q;
    logic [DepthW-1:0] cnt_q;
    logic              empty;
    logic              bypass;
    logic              push;
    logic              pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign empty    = (cnt_q == '0);
    assign wready_o = (cnt_q < DepthW'(Depth));
    assign bypass   = Pass & empty & wvalid_i & rready_i;
    assign push     = wvalid_i & wready_o & ~bypass;
    assign pop      = rready_i & ~empty;
    assign rvalid_o = ~empty | (Pass & wvalid_i);
    assign rdata_o  = (Pass && empty) ? wdata_i : mem[rptr_q];
    assign depth_o  = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + DepthW'(1);
                2'b01:   cnt_q <= cnt_q - DepthW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rv_plic_claim_seq.sv
// Hardware claim/complete sequencer for one PLIC target: claims the top interrupt, offers its ID
// to a consumer, tracks in-flight IDs and completes them in order (or on service timeout).
module rv_plic_claim_seq
    import rv_plic_claim_pkg::*;
#(
    parameter int N_SOURCE        = 32,
    parameter int SRCW            = $clog2(N_SOURCE + 1),
    parameter int MAX_OUTSTANDING = 4,
    parameter int TMO_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [TMO_W-1:0] timeout_i,
    input  logic             irq_i,
    input  logic [SRCW-1:0]  irq_id_i,
    output logic             claim_o,
    output logic [SRCW-1:0]  claim_id_o,
    output logic             complete_o,
    output logic [SRCW-1:0]  complete_id_o,
    output logic             evt_valid_o,
    output logic [SRCW-1:0]  evt_id_o,
    input  logic             evt_ready_i,
    input  logic             done_valid_i,
    input  logic [SRCW-1:0]  done_id_i,
    output logic             done_ready_o,
    output logic             busy_o,
    output logic             tmo_o,
    output logic             err_o
);

    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

    claim_state_e     state_q, state_d;
    logic [SRCW-1:0]  id_q, id_d;

    logic             fifo_wvalid;
    logic             fifo_wready;
    logic             fifo_rvalid;
    logic             fifo_rready;
    logic [SRCW-1:0]  fifo_head;
    logic [CNTW-1:0]  fifo_cnt;

    logic             complete_q;
    logic [SRCW-1:0]  complete_id_q;
    logic             tmo_q;
    logic             err_q;
    logic [TMO_W-1:0] tmo_cnt_q;

    logic             claim_ok;
    logic             done_hs;
    logic             tmo_fire;
    logic             pop;

    // Claim gating counts only FIFO entries; no sequence is in progress while IDLE,
    // so the FIFO can never be full when the offer handshake pushes.
    assign claim_ok = enable_i & irq_i & (irq_id_i != '0) &
                      (fifo_cnt < CNTW'(MAX_OUTSTANDING));

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        fifo_wvalid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (claim_ok) begin
                    id_d    = irq_id_i;
                    state_d = CLAIM;
                end
            end
            CLAIM: state_d = HOLD;
            HOLD:  state_d = OFFER;
            OFFER: begin
                if (evt_ready_i) begin
                    fifo_wvalid = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign claim_o     = (state_q == CLAIM);
    assign claim_id_o  = (state_q == CLAIM) ? id_q : '0;
    assign evt_valid_o = (state_q == OFFER);
    assign evt_id_o    = (state_q == OFFER) ? id_q : '0;
    assign busy_o      = (fifo_cnt != '0) | (state_q != IDLE);

    prim_fifo_sync #(
        .Width (SRCW),
        .Depth (MAX_OUTSTANDING),
        .Pass  (1'b0),
        .DepthW(CNTW)
    ) u_inflight (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wvalid_i(fifo_wvalid),
        .wready_o(fifo_wready),
        .wdata_i (id_q),
        .rvalid_o(fifo_rvalid),
        .rready_i(fifo_rready),
        .rdata_o (fifo_head),
        .depth_o (fifo_cnt)
    );

    // A pending registered complete blocks both pop sources, keeping complete_o a single pulse.
    assign done_ready_o = fifo_rvalid & ~complete_q;
    assign done_hs      = done_valid_i & done_ready_o;
    assign tmo_fire     = (timeout_i != '0) & fifo_rvalid & ~complete_q & ~done_hs &
                          (tmo_cnt_q == timeout_i - TMO_W'(1));
    assign pop          = done_hs | tmo_fire;
    assign fifo_rready  = pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            complete_q    <= 1'b0;
            complete_id_q <= '0;
            tmo_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            complete_q    <= pop;
            complete_id_q <= pop ? fifo_head : '0;
            tmo_q         <= tmo_fire;
            if (done_hs && (done_id_i != fifo_head)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Service age of the current head; held during the complete cycle so a timeout of 1 still fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (pop || !fifo_rvalid) begin
            tmo_cnt_q <= '0;
        end else if (!complete_q && (tmo_cnt_q != '1)) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    assign complete_o    = complete_q;
    assign complete_id_o = complete_id_q;
    assign tmo_o         = tmo_q;
    assign err_o         = err_q;

    a_claim_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        claim_o |=> !claim_o);
    a_complete_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        complete_o |=> !complete_o);
    a_tmo_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        tmo_o |=> !tmo_o);
    a_evt_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (evt_valid_o && !evt_ready_i) |=> (evt_valid_o && $stable(evt_id_o)));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_wvalid |-> fifo_wready);

endmodule

// File: tb/tb_rv_plic_claim_seq.sv
// Self-checking bench for rv_plic_claim_seq: directed scenarios followed by a randomized phase,
// all outputs compared every cycle against a queue-based reference model of the sequencer.
module tb_rv_plic_claim_seq;

    localparam int N_SOURCE = 32;
    localparam int SRCW     = 6;
    localparam int MAX_OUT  = 4;
    localparam int TMO_W    = 16;

    logic             clk_i;
    logic             rst_ni;
    logic             enable_i;
    logic [TMO_W-1:0] timeout_i;
    logic             irq_i;
    logic [SRCW-1:0]  irq_id_i;
    logic             claim_o;
    logic [SRCW-1:0]  claim_id_o;
    logic             complete_o;
    logic [SRCW-1:0]  complete_id_o;
    logic             evt_valid_o;
    logic [SRCW-1:0]  evt_id_o;
    logic             evt_ready_i;
    logic             done_valid_i;
    logic [SRCW-1:0]  done_id_i;
    logic             done_ready_o;
    logic             busy_o;
    logic             tmo_o;
    logic             err_o;

    rv_plic_claim_seq #(
        .N_SOURCE       (N_SOURCE),
        .SRCW           (SRCW),
        .MAX_OUTSTANDING(MAX_OUT),
        .TMO_W          (TMO_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .timeout_i    (timeout_i),
        .irq_i        (irq_i),
        .irq_id_i     (irq_id_i),
        .claim_o      (claim_o),
        .claim_id_o   (claim_id_o),
        .complete_o   (complete_o),
        .complete_id_o(complete_id_o),
        .evt_valid_o  (evt_valid_o),
        .evt_id_o     (evt_id_o),
        .evt_ready_i  (evt_ready_i),
        .done_valid_i (done_valid_i),
        .done_id_i    (done_id_i),
        .done_ready_o (done_ready_o),
        .busy_o       (busy_o),
        .tmo_o        (tmo_o),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference model: m_seq_age counts cycles since the claim decision (-1 = no sequence,
    // 1 = claim cycle, 3 = offering); m_q holds in-flight IDs oldest first.
    int m_seq_age;
    int m_seq_id;
    int m_q[$];
    bit m_cmpl;
    int m_cmpl_id;
    bit m_tmo;
    bit m_err;
    int m_age;

    // PLIC stand-in for the random phase: pending bits, registered (one-cycle stale) top ID.
    bit               use_stub = 1'b0;
    bit [N_SOURCE:0]  pend     = '0;
    int               stub_claimed = 0;

    // Observations of the DUT itself, used for latency and pulse-count checks.
    int dut_claims = 0;
    int dut_cmpls  = 0;
    int dut_tmos   = 0;
    int last_hs_cyc    = -1;
    int last_cmpl_cyc  = -1;
    int last_cmpl_id   = -1;
    int first_claim_cyc = -1;
    int first_evt_cyc   = -1;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        m_seq_age    = -1;
        m_seq_id     = 0;
        m_q.delete();
        m_cmpl       = 1'b0;
        m_cmpl_id    = 0;
        m_tmo        = 1'b0;
        m_err        = 1'b0;
        m_age        = 0;
        stub_claimed = 0;
    endtask

    task automatic checkAll();
        checkOutput("claim",       int'(claim_o),       int'(m_seq_age == 1));
        checkOutput("claim_id",    int'(claim_id_o),    (m_seq_age == 1) ? m_seq_id : 0);
        checkOutput("evt_valid",   int'(evt_valid_o),   int'(m_seq_age >= 3));
        checkOutput("evt_id",      int'(evt_id_o),      (m_seq_age >= 3) ? m_seq_id : 0);
        checkOutput("complete",    int'(complete_o),    int'(m_cmpl));
        checkOutput("complete_id", int'(complete_id_o), m_cmpl_id);
        checkOutput("tmo",         int'(tmo_o),         int'(m_tmo));
        checkOutput("done_ready",  int'(done_ready_o),  int'(m_q.size() != 0 && !m_cmpl));
        checkOutput("busy",        int'(busy_o),        int'(m_q.size() != 0 || m_seq_age >= 0));
        checkOutput("err",         int'(err_o),         int'(m_err));
        if (claim_o) begin
            dut_claims++;
            if (first_claim_cyc < 0) first_claim_cyc = cyc;
        end
        if (evt_valid_o && first_evt_cyc < 0) first_evt_cyc = cyc;
        if (evt_valid_o && evt_ready_i) last_hs_cyc = cyc;
        if (complete_o) begin
            dut_cmpls++;
            last_cmpl_cyc = cyc;
            last_cmpl_id  = int'(complete_id_o);
        end
        if (tmo_o) dut_tmos++;
    endtask

    // Advance the model across the coming clock edge using this cycle's inputs.
    task automatic modelUpdate();
        bit offer_hs, done_hs, tmo_fire, trig, popped;
        int head;
        if (!rst_ni) begin
            modelReset();
        end else begin
            head     = (m_q.size() != 0) ? m_q[0] : 0;
            offer_hs = (m_seq_age >= 3) && evt_ready_i;
            done_hs  = done_valid_i && (m_q.size() != 0) && !m_cmpl;
            tmo_fire = (timeout_i != 0) && (m_q.size() != 0) && !m_cmpl && !done_hs &&
                       (m_age == int'(timeout_i) - 1);
            trig     = (m_seq_age < 0) && enable_i && irq_i && (irq_id_i != 0) &&
                       (m_q.size() < MAX_OUT);
            popped   = done_hs || tmo_fire;
            stub_claimed = (m_seq_age == 1) ? m_seq_id : 0;
            if (popped || m_q.size() == 0) m_age = 0;
            else if (!m_cmpl && m_age < 65535) m_age++;
            if (done_hs && int'(done_id_i) != head) m_err = 1'b1;
            m_cmpl    = popped;
            m_cmpl_id = popped ? head : 0;
            m_tmo     = tmo_fire;
            if (popped) void'(m_q.pop_front());
            if (offer_hs) begin
                m_q.push_back(m_seq_id);
                m_seq_age = -1;
            end else if (m_seq_age >= 0) begin
                if (m_seq_age < 3) m_seq_age++;
            end else if (trig) begin
                m_seq_age = 1;
                m_seq_id  = int'(irq_id_i);
            end
        end
        cyc++;
    endtask

    task automatic stubTick();
        int top = 0;
        for (int i = 1; i <= N_SOURCE; i++) if (pend[i]) top = i;
        irq_id_i = SRCW'(top);
        irq_i    = (top != 0);
        if (stub_claimed != 0) pend[stub_claimed] = 1'b0;
        if ($urandom_range(0, 5) == 0) pend[$urandom_range(1, N_SOURCE)] = 1'b1;
    endtask

    // One clock cycle: check at the falling edge, update the model, then let the caller drive.
    task automatic applyStimulus();
        @(negedge clk_i);
        checkAll();
        modelUpdate();
        @(posedge clk_i);
        #1;
        if (use_stub) stubTick();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic waitClaim(input string tag);
        int n = 0;
        while (m_seq_age != 1 && n < 40) begin
            applyStimulus();
            n++;
        end
        if (m_seq_age != 1) checkOutput(tag, m_seq_age, 1);
    endtask

    // Complete every in-flight ID in order and return to an idle sequencer.
    task automatic drainAll(input string tag);
        int n = 0;
        irq_i = 1'b0;
        evt_ready_i = 1'b1;
        while ((m_q.size() != 0 || m_seq_age >= 0 || m_cmpl) && n < 100) begin
            done_valid_i = (m_q.size() != 0);
            done_id_i    = (m_q.size() != 0) ? SRCW'(m_q[0]) : '0;
            applyStimulus();
            n++;
        end
        done_valid_i = 1'b0;
        applyStimulus();
        checkOutput(tag, int'(busy_o), 0);
    endtask

    int t0;
    int c0;
    int ids2[5] = '{3, 7, 9, 2, 4};

    initial begin
        rst_ni       = 1'b0;
        enable_i     = 1'b1;
        timeout_i    = '0;
        irq_i        = 1'b0;
        irq_id_i     = '0;
        evt_ready_i  = 1'b0;
        done_valid_i = 1'b0;
        done_id_i    = '0;
        modelReset();
        runCycles(3);
        rst_ni = 1'b1;
        runCycles(2);

        // Single interrupt: claim one cycle after the decision, offer three after, complete after done.
        evt_ready_i = 1'b1;
        irq_i = 1'b1;
        irq_id_i = 6'd5;
        first_claim_cyc = -1;
        first_evt_cyc = -1;
        t0 = cyc;
        applyStimulus();
        irq_i = 1'b0;
        irq_id_i = '0;
        runCycles(4);
        checkOutput("t1_claim_lat", first_claim_cyc - t0, 1);
        checkOutput("t1_offer_lat", first_evt_cyc - t0, 3);
        done_valid_i = 1'b1;
        done_id_i = 6'd5;
        applyStimulus();
        done_valid_i = 1'b0;
        runCycles(2);
        checkOutput("t1_complete_id", last_cmpl_id, 5);

        // Five IDs back to back with no completions: only MAX_OUT are claimed.
        c0 = dut_claims;
        for (int i = 0; i < 5; i++) begin
            irq_i = 1'b1;
            irq_id_i = SRCW'(ids2[i]);
            if (i < 4) waitClaim("t2_wait_claim");
        end
        runCycles(15);
        checkOutput("t2_claims_held", dut_claims - c0, 4);
        done_valid_i = 1'b1;
        done_id_i = 6'd3;
        applyStimulus();
        done_valid_i = 1'b0;
        waitClaim("t2_wait_fifth");
        irq_i = 1'b0;
        runCycles(4);
        checkOutput("t2_claims_total", dut_claims - c0, 5);
        drainAll("t2_drained");

        // Timeout: forced complete 10 cycles after the ID enters the FIFO; disabled when 0.
        timeout_i = 16'd10;
        c0 = dut_cmpls;
        t0 = dut_tmos;
        irq_i = 1'b1;
        irq_id_i = 6'd6;
        waitClaim("t3_wait_claim");
        irq_i = 1'b0;
        for (int n = 0; n < 40 && dut_cmpls == c0; n++) applyStimulus();
        checkOutput("t3_complete_seen", dut_cmpls - c0, 1);
        checkOutput("t3_latency", last_cmpl_cyc - (last_hs_cyc + 1), 10);
        checkOutput("t3_tmo_count", dut_tmos - t0, 1);
        checkOutput("t3_tmo_id", last_cmpl_id, 6);
        timeout_i = '0;
        c0 = dut_cmpls;
        irq_i = 1'b1;
        waitClaim("t3_wait_claim2");
        irq_i = 1'b0;
        runCycles(40);
        checkOutput("t3_no_timeout", dut_cmpls - c0, 0);
        drainAll("t3_drained");

        // Wrong done ID: head is still completed and err_o latches.
        irq_i = 1'b1;
        irq_id_i = 6'd3;
        waitClaim("t4_claim3");
        irq_id_i = 6'd7;
        waitClaim("t4_claim7");
        irq_i = 1'b0;
        runCycles(4);
        done_valid_i = 1'b1;
        done_id_i = 6'd7;
        applyStimulus();
        done_valid_i = 1'b0;
        applyStimulus();
        checkOutput("t4_err", int'(err_o), 1);
        checkOutput("t4_complete_id", last_cmpl_id, 3);
        drainAll("t4_drained");
        checkOutput("t4_err_sticky", int'(err_o), 1);

        // Consumer stalls the offer while irq_id_i keeps changing.
        evt_ready_i = 1'b0;
        c0 = dut_claims;
        irq_i = 1'b1;
        irq_id_i = 6'd11;
        waitClaim("t5_claim");
        for (int i = 0; i < 20; i++) begin
            irq_id_i = SRCW'($urandom_range(1, N_SOURCE));
            applyStimulus();
        end
        checkOutput("t5_offer_id", int'(evt_id_o), 11);
        checkOutput("t5_single_claim", dut_claims - c0, 1);
        irq_i = 1'b0;
        drainAll("t5_drained");

        // Randomized traffic from the PLIC stand-in with random consumer behaviour.
        use_stub = 1'b1;
        pend = '0;
        for (int blk = 0; blk < 8; blk++) begin
            timeout_i = ($urandom_range(0, 2) == 0) ? '0 : TMO_W'($urandom_range(1, 25));
            for (int i = 0; i < 200; i++) begin
                evt_ready_i  = ($urandom_range(0, 3) != 0);
                enable_i     = ($urandom_range(0, 15) != 0);
                done_valid_i = (m_q.size() != 0) && ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 15) == 0) done_id_i = SRCW'($urandom_range(1, N_SOURCE));
                else done_id_i = (m_q.size() != 0) ? SRCW'(m_q[0]) : '0;
                applyStimulus();
            end
        end
        use_stub = 1'b0;
        enable_i = 1'b1;
        timeout_i = '0;
        drainAll("rnd_drained");

        // Reset while the sequence sits in HOLD drops the claimed ID.
        irq_i = 1'b1;
        irq_id_i = 6'd8;
        waitClaim("t6_claim");
        applyStimulus();
        checkOutput("t6_in_hold", m_seq_age, 2);
        rst_ni = 1'b0;
        #1;
        modelReset();
        checkOutput("t6_claim_now", int'(claim_o), 0);
        checkOutput("t6_evt_now", int'(evt_valid_o), 0);
        checkOutput("t6_busy_now", int'(busy_o), 0);
        checkOutput("t6_err_now", int'(err_o), 0);
        irq_i = 1'b0;
        irq_id_i = '0;
        runCycles(2);
        rst_ni = 1'b1;
        runCycles(6);
        checkOutput("t6_fifo_empty", int'(done_ready_o), 0);
        checkOutput("t6_busy_after", int'(busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
